// File: rtl/riscv_pkg.sv
// Shared fetch-side types and constants for the front end.
// Consumed by fetch_stage and its downstream bubble logic.
package riscv_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DROP = 2'd3
    } fetch_state_t;

    localparam int unsigned INSTR_BYTES = 4;
    localparam logic [31:0] NOP_INSTR   = 32'h0000_0013;

endpackage

// File: rtl/fetch_stage.sv
// Instruction fetch: owns the PC, one outstanding imem request, single-entry output buffer.
// Request issued the cycle after grant resolves; no new request while the buffer is full and not draining.
module fetch_stage
    import riscv_pkg::*;
#(
    parameter int unsigned     XLEN      = 32,
    parameter int unsigned     IMM_WIDTH = 12,
    parameter logic [XLEN-1:0] RESET_PC  = '0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    output logic                 imem_req,
    output logic [XLEN-1:0]      imem_addr,
    input  logic                 imem_gnt,
    input  logic                 imem_rvalid,
    input  logic [31:0]          imem_rdata,
    input  logic                 br_take,
    input  logic [XLEN-1:0]      br_pc,
    input  logic [XLEN-1:0]      br_imm,
    output logic                 if_valid,
    input  logic                 if_ready,
    output logic [31:0]          if_instr,
    output logic [XLEN-1:0]      if_pc,
    output logic [IMM_WIDTH-1:0] if_imm12
);

    fetch_state_t    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] req_pc_q, req_pc_d;
    logic            valid_q, valid_d;
    logic [31:0]     instr_q, instr_d;
    logic [XLEN-1:0] ipc_q, ipc_d;

    logic            drain;
    logic            req;
    logic [XLEN-1:0] br_sum;
    logic [XLEN-1:0] br_target;
    logic [XLEN-1:0] pc_next;

    assign drain     = valid_q && if_ready;
    assign req       = (state_q == REQ) && (!valid_q || if_ready);
    assign br_sum    = br_pc + br_imm;
    assign br_target = {br_sum[XLEN-1:2], 2'b00};
    assign pc_next   = pc_q + XLEN'(INSTR_BYTES);

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        req_pc_d = req_pc_q;
        valid_d  = drain ? 1'b0 : valid_q;
        instr_d  = instr_q;
        ipc_d    = ipc_q;

        if (br_take) begin
            // Redirect wins; anything already granted must be swallowed in DROP.
            pc_d    = br_target;
            valid_d = 1'b0;
            case (state_q)
                IDLE:    state_d = REQ;
                REQ:     state_d = (req && imem_gnt) ? DROP : REQ;
                WAIT:    state_d = imem_rvalid ? REQ : DROP;
                DROP:    state_d = imem_rvalid ? REQ : DROP;
                default: state_d = IDLE;
            endcase
        end else begin
            case (state_q)
                IDLE: state_d = REQ;
                REQ: begin
                    if (req && imem_gnt) begin
                        req_pc_d = pc_q;
                        pc_d     = pc_next;
                        state_d  = WAIT;
                    end
                end
                WAIT: begin
                    if (imem_rvalid) begin
                        instr_d = imem_rdata;
                        ipc_d   = req_pc_q;
                        valid_d = 1'b1;
                        state_d = REQ;
                    end
                end
                DROP: begin
                    if (imem_rvalid) begin
                        state_d = REQ;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            pc_q     <= RESET_PC;
            req_pc_q <= '0;
            valid_q  <= 1'b0;
            instr_q  <= '0;
            ipc_q    <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            req_pc_q <= req_pc_d;
            valid_q  <= valid_d;
            instr_q  <= instr_d;
            ipc_q    <= ipc_d;
        end
    end

    assign imem_req  = req;
    assign imem_addr = req ? pc_q : '0;
    assign if_valid  = valid_q;
    assign if_instr  = instr_q;
    assign if_pc     = ipc_q;
    assign if_imm12  = instr_q[31 -: IMM_WIDTH];

endmodule

// File: tb/tb_fetch_stage.sv
// Randomized bench for fetch_stage: memory model, fetch-address model and delivery scoreboard.
module tb_fetch_stage;
    import riscv_pkg::*;

    localparam int          NCYC   = 3000;
    localparam logic [31:0] RST_PC = 32'h0;

    logic        clk;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        br_take;
    logic [31:0] br_pc;
    logic [31:0] br_imm;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic [11:0] if_imm12;

    fetch_stage #(.XLEN(32), .IMM_WIDTH(12), .RESET_PC(RST_PC)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .br_take(br_take), .br_pc(br_pc), .br_imm(br_imm),
        .if_valid(if_valid), .if_ready(if_ready), .if_instr(if_instr),
        .if_pc(if_pc), .if_imm12(if_imm12)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          n_deliv  = 0;
    logic [31:0] sb_q[$];
    logic [31:0] next_push;

    // Memory content: address 0 holds 32'hFFF00093 (addi x1,x0,-1).
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'hFFF0_0093 ^ {a[19:0], 12'h000} ^ {20'h0, a[31:20]};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic sb_restart(input logic [31:0] start);
        sb_q.delete();
        next_push = start;
    endtask

    // Monitor: every accepted instruction must be the next one in program order.
    always @(negedge clk) begin
        logic [31:0] exp_pc;
        logic [31:0] exp_i;
        if (rst_n && if_valid && if_ready && !br_take) begin
            n_deliv++;
            if (sb_q.size() == 0) begin
                chk("sb_empty", 32'd0, 32'd1);
            end else begin
                exp_pc = sb_q.pop_front();
                exp_i  = mem_word(exp_pc);
                chk("if_pc", if_pc, exp_pc);
                chk("if_instr", if_instr, exp_i);
                chk("if_imm12", {20'h0, if_imm12}, {20'h0, exp_i[31:20]});
            end
        end
    end

    logic [31:0] fetch_exp;
    logic        outstanding;
    logic        stale;
    logic [31:0] out_addr;
    int          cnt;
    int          rel_cyc;
    bit          did_rst;
    int          rst_cyc;
    logic [31:0] tgt;

    initial begin
        rst_n = 1'b0; imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
        br_take = 1'b0; br_pc = '0; br_imm = '0; if_ready = 1'b0;
        outstanding = 1'b0; stale = 1'b0; out_addr = '0; cnt = 0;
        rel_cyc = 3; did_rst = 1'b0; rst_cyc = 0; tgt = '0;
        fetch_exp = RST_PC;
        sb_restart(RST_PC);

        for (int cyc = 0; cyc < NCYC; cyc++) begin
            @(posedge clk); #1;
            if (cyc == 3) rst_n = 1'b1;
            if (!did_rst && cyc >= 1500 && outstanding && !stale && cnt > 0) begin
                rst_n   = 1'b0;
                did_rst = 1'b1;
                rst_cyc = cyc;
                stale   = 1'b1;
                cnt     = 2;
            end
            if (did_rst && !rst_n && cyc == rst_cyc + 2) begin
                rst_n   = 1'b1;
                rel_cyc = cyc;
            end

            imem_rvalid = outstanding && (cnt == 0);
            imem_rdata  = imem_rvalid ? mem_word(out_addr) : $urandom;
            imem_gnt    = !outstanding && ((cyc < 30) || ($urandom_range(0, 2) != 0));
            if_ready    = (cyc < 30) || ($urandom_range(0, 3) != 0);
            br_take     = rst_n && (cyc >= 30) && (cyc >= rel_cyc + 2) && ($urandom_range(0, 19) == 0);
            case ($urandom_range(0, 3))
                0: begin br_pc = 32'h0000_0100; br_imm = 32'hFFFF_FFF8; end
                1: begin br_pc = 32'hFFFF_FFF0; br_imm = 32'h0000_0012; end
                default: begin
                    br_pc  = $urandom_range(0, 32'hFFFF) & 32'hFFFF_FFFC;
                    br_imm = 32'($signed($urandom_range(0, 511)) - 256);
                end
            endcase

            @(negedge clk); #2;
            if (!rst_n) begin
                chk("rst_imem_req", {31'h0, imem_req}, 32'd0);
                chk("rst_imem_addr", imem_addr, 32'd0);
                chk("rst_if_valid", {31'h0, if_valid}, 32'd0);
                chk("rst_if_instr", if_instr, 32'd0);
                chk("rst_if_pc", if_pc, 32'd0);
                chk("rst_if_imm12", {20'h0, if_imm12}, 32'd0);
                fetch_exp = RST_PC;
                sb_restart(RST_PC);
            end else begin
                if (cyc == rel_cyc + 1) begin
                    chk("first_req_after_reset", {31'h0, imem_req}, 32'd1);
                end
                if (imem_req) begin
                    chk("imem_addr", imem_addr, fetch_exp);
                    chk("req_while_busy", {31'h0, outstanding && !stale}, 32'd0);
                end
                if (if_valid && !if_ready) begin
                    chk("req_while_full", {31'h0, imem_req}, 32'd0);
                end
                if (br_take) begin
                    tgt = (br_pc + br_imm) & 32'hFFFF_FFFC;
                    fetch_exp = tgt;
                    sb_restart(tgt);
                end else if (imem_req && imem_gnt) begin
                    fetch_exp = fetch_exp + 32'd4;
                end
            end

            if (imem_rvalid) begin
                outstanding = 1'b0;
                stale       = 1'b0;
            end else if (outstanding && cnt > 0) begin
                cnt--;
            end
            if (rst_n && imem_req && imem_gnt) begin
                outstanding = 1'b1;
                out_addr    = imem_addr;
                cnt         = (cyc < 30) ? 0 : $urandom_range(0, 3);
            end
            while (sb_q.size() < 8) begin
                sb_q.push_back(next_push);
                next_push = next_push + 32'd4;
            end
        end

        chk("reset_exercised", {31'h0, did_rst}, 32'd1);
        chk("enough_deliveries", {31'h0, n_deliv > 200}, 32'd1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
